// File: rtl/lsp_expand_1_2.sv
// -----------------------------------------------------------------------------
// lsp_expand_1_2
//   Reads a 10-coefficient Q13 LSP vector from scratch memory, runs two
//   minimum-spacing expansion passes over it (gap GAP1, then gap GAP2) and
//   writes the expanded vector back to the same addresses.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          one-cycle pulse, accepted only while idle
//   bufAddr        vector base address, element i lives at {bufAddr[10:4], i}
//   readRequested  memory read address (RAM returns data one cycle later)
//   readIn         memory read data, [15:0] is a signed Q13 coefficient
//   writeRequested memory write address
//   writeOut       write data, sign-extended 16-bit coefficient
//   write          write enable, one word per cycle
//   done           one-cycle completion pulse
// -----------------------------------------------------------------------------
module lsp_expand_1_2 #(
  parameter int M      = 10,
  parameter int GAP1   = 10,
  parameter int GAP2   = 5,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] bufAddr,
  output logic [ADDR_W-1:0] readRequested,
  input  logic [DATA_W-1:0] readIn,
  output logic [ADDR_W-1:0] writeRequested,
  output logic [DATA_W-1:0] writeOut,
  output logic              write,
  output logic              done
);

  localparam int                 BASE_W   = ADDR_W - 4;
  localparam logic [3:0]         LAST_IDX = 4'(M - 1);
  localparam logic signed [16:0] GAP1_Q   = 17'(GAP1);
  localparam logic signed [16:0] GAP2_Q   = 17'(GAP2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_CAP  = 3'd2,
    S_PASS1   = 3'd3,
    S_PASS2   = 3'd4,
    S_WR      = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BASE_W-1:0]  r_base;
  logic [3:0]         r_idx;
  logic signed [15:0] r_buf [M];

  logic [ADDR_W-1:0]  r_rd_addr;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_write;
  logic               r_done;

  // Clamp a 17-bit intermediate into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
    if (x[16] != x[15]) begin
      sat16 = x[16] ? 16'sh8000 : 16'sh7FFF;
    end else begin
      sat16 = x[15:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Expansion step datapath for the pair (j-1, j) with j = r_idx
  // ---------------------------------------------------------------------------
  logic [3:0]         w_jm1;
  logic signed [15:0] w_a;
  logic signed [15:0] w_b;
  logic signed [16:0] w_gap;
  logic signed [15:0] w_diff;
  logic signed [15:0] w_sum;
  logic signed [15:0] w_tmp;
  logic               w_apply;
  logic signed [15:0] w_new_a;
  logic signed [15:0] w_new_b;

  assign w_jm1 = r_idx - 4'd1;

  // Operand fetch; the guard keeps the index inside the buffer outside the passes.
  always_comb begin
    if ((r_idx != 4'd0) && (r_idx <= LAST_IDX)) begin
      w_a = r_buf[w_jm1];
      w_b = r_buf[r_idx];
    end else begin
      w_a = 16'sd0;
      w_b = 16'sd0;
    end
  end

  assign w_gap   = (r_state == S_PASS1) ? GAP1_Q : GAP2_Q;
  assign w_diff  = sat16({w_a[15], w_a} - {w_b[15], w_b});
  assign w_sum   = sat16({w_diff[15], w_diff} + w_gap);
  assign w_tmp   = {w_sum[15], w_sum[15:1]};
  assign w_apply = (w_tmp > 16'sd0);
  assign w_new_a = sat16({w_a[15], w_a} - {w_tmp[15], w_tmp});
  assign w_new_b = sat16({w_b[15], w_b} + {w_tmp[15], w_tmp});

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; r_idx doubles as read index, pass index j and write index.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RD_ADDR;
        else       w_state_next = S_IDLE;
      end
      S_RD_ADDR: w_state_next = S_RD_CAP;
      S_RD_CAP: begin
        if (r_idx == LAST_IDX) w_state_next = S_PASS1;
        else                   w_state_next = S_RD_ADDR;
      end
      S_PASS1: begin
        if (r_idx == LAST_IDX) w_state_next = S_PASS2;
        else                   w_state_next = S_PASS1;
      end
      S_PASS2: begin
        if (r_idx == LAST_IDX) w_state_next = S_WR;
        else                   w_state_next = S_PASS2;
      end
      S_WR: begin
        if (r_idx == LAST_IDX) w_state_next = S_DONE;
        else                   w_state_next = S_WR;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: memory outputs are registered, so they are computed one
  // cycle ahead from the next state.
  logic               w_rd_load;
  logic [3:0]         w_rd_sel;
  logic [BASE_W-1:0]  w_rd_base;
  logic [3:0]         w_wr_sel;
  logic signed [15:0] w_wr_word;
  logic               w_write_next;
  logic               w_done_next;

  // Output-side combinational decode.
  always_comb begin
    w_rd_load    = (w_state_next == S_RD_ADDR);
    w_rd_sel     = (r_state == S_RD_CAP) ? (r_idx + 4'd1) : 4'd0;
    w_rd_base    = (r_state == S_IDLE) ? bufAddr[ADDR_W-1:4] : r_base;
    // Word 0 is fetched on the last PASS2 step; that step only touches
    // elements M-2 and M-1, so element 0 is already final.
    w_wr_sel     = (r_state == S_WR) ? (r_idx + 4'd1) : 4'd0;
    if (w_wr_sel <= LAST_IDX) begin
      w_wr_word = r_buf[w_wr_sel];
    end else begin
      w_wr_word = 16'sd0;
    end
    w_write_next = (w_state_next == S_WR);
    w_done_next  = (w_state_next == S_DONE);
  end

  // Registered memory interface and completion pulse; addresses/data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_write   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_rd_load) begin
        r_rd_addr <= {w_rd_base, w_rd_sel};
      end
      if (w_write_next) begin
        r_wr_addr <= {r_base, w_wr_sel};
        r_wr_data <= {{(DATA_W-16){w_wr_word[15]}}, w_wr_word};
      end
      r_write <= w_write_next;
      r_done  <= w_done_next;
    end
  end

  // Base latch, index sequencing, capture of read data and pass updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base <= '0;
      r_idx  <= 4'd0;
      for (int k = 0; k < M; k++) begin
        r_buf[k] <= 16'sd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base <= bufAddr[ADDR_W-1:4];
            r_idx  <= 4'd0;
          end
        end
        S_RD_CAP: begin
          for (int k = 0; k < M; k++) begin
            if (4'(k) == r_idx) r_buf[k] <= readIn[15:0];
          end
          r_idx <= (r_idx == LAST_IDX) ? 4'd1 : (r_idx + 4'd1);
        end
        S_PASS1, S_PASS2: begin
          for (int k = 0; k < M; k++) begin
            if (w_apply && (4'(k) == w_jm1))      r_buf[k] <= w_new_a;
            else if (w_apply && (4'(k) == r_idx)) r_buf[k] <= w_new_b;
          end
          if (r_idx == LAST_IDX) begin
            r_idx <= (r_state == S_PASS1) ? 4'd1 : 4'd0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_WR: begin
          r_idx <= (r_idx == LAST_IDX) ? 4'd0 : (r_idx + 4'd1);
        end
        default: begin
        end
      endcase
    end
  end

  // Upper read-data bits and the in-vector address bits carry no information.
  logic w_unused;
  assign w_unused = ^{readIn[DATA_W-1:16], bufAddr[3:0]};

  assign readRequested  = r_rd_addr;
  assign writeRequested = r_wr_addr;
  assign writeOut       = r_wr_data;
  assign write          = r_write;
  assign done           = r_done;

endmodule

// File: tb/tb_lsp_expand_1_2.sv
// -----------------------------------------------------------------------------
// tb_lsp_expand_1_2
//   Directed bench for lsp_expand_1_2 with a registered one-cycle-latency RAM
//   model. Each scenario task drives a frame and checks results inline.
// -----------------------------------------------------------------------------
module tb_lsp_expand_1_2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] bufAddr;
  logic [10:0] readRequested;
  logic [31:0] readIn;
  logic [10:0] writeRequested;
  logic [31:0] writeOut;
  logic        write;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [2048];

  int          n_wr    = 0;
  int          n_rd    = 0;
  int          n_done  = 0;
  int          n_clash = 0;
  logic [10:0] wr_addr_log [2048];
  logic [31:0] wr_data_log [2048];
  logic [10:0] rd_log      [2048];
  logic [10:0] prev_rd = 11'd0;

  int f_lat, f_wr0, f_rd0, f_done0, f_clash0;
  int vec   [10];
  int exp_v [10];
  int mv    [10];
  int exp_all [60][10];

  lsp_expand_1_2 dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .bufAddr        (bufAddr),
    .readRequested  (readRequested),
    .readIn         (readIn),
    .writeRequested (writeRequested),
    .writeOut       (writeOut),
    .write          (write),
    .done           (done)
  );

  // Clock.
  always #5 clk = ~clk;

  // Registered RAM read port.
  always @(posedge clk) begin
    readIn <= mem[readRequested];
  end

  // Monitor: logs writes, new read addresses and done pulses.
  always @(negedge clk) begin
    if (write) begin
      if (n_wr < 2048) begin
        wr_addr_log[n_wr] <= writeRequested;
        wr_data_log[n_wr] <= writeOut;
      end
      n_wr <= n_wr + 1;
      if (readRequested != prev_rd) n_clash <= n_clash + 1;
    end
    if (readRequested != prev_rd) begin
      if (n_rd < 2048) rd_log[n_rd] <= readRequested;
      n_rd <= n_rd + 1;
    end
    if (done) n_done <= n_done + 1;
    prev_rd <= readRequested;
  end

  function automatic int clamp16(input int x);
    if (x > 32767) return 32767;
    else if (x < -32768) return -32768;
    else return x;
  endfunction

  // Reference expansion pass on mv[], written from the C algorithm.
  function automatic void model_pass(input int gap);
    int d, t;
    for (int j = 1; j < 10; j++) begin
      d = clamp16(mv[j-1] - mv[j]);
      t = clamp16(d + gap) >>> 1;
      if (t > 0) begin
        mv[j-1] = clamp16(mv[j-1] - t);
        mv[j]   = clamp16(mv[j] + t);
      end
    end
  endfunction

  task automatic load_vec(input logic [10:0] base);
    for (int i = 0; i < 10; i++) begin
      mem[base + 11'(i)] = {16'h5A5A, 16'(vec[i])};
    end
  endtask

  // Start a frame on the next negedge; cycle 0 is the cycle start is sampled.
  task automatic run_frame(input logic [10:0] base, input int p1, input int p2, input int tail);
    int cyc;
    @(negedge clk);
    f_wr0 = n_wr; f_rd0 = n_rd; f_done0 = n_done; f_clash0 = n_clash;
    bufAddr = base;
    start   = 1'b1;
    cyc     = 0;
    f_lat   = -1;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done && (f_lat < 0)) f_lat = cyc;
      start = ((cyc == p1) || (cyc == p2)) ? 1'b1 : 1'b0;
      if ((f_lat >= 0) && (cyc >= f_lat + tail)) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bufAddr = 11'h7F0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (readRequested !== 11'd0) begin n_fail++; $display("FAIL reset_rdaddr got %h want 000", readRequested); end
    n_tests++; if (writeRequested !== 11'd0) begin n_fail++; $display("FAIL reset_wraddr got %h want 000", writeRequested); end
    n_tests++; if (writeOut !== 32'd0) begin n_fail++; $display("FAIL reset_wrdata got %h want 0", writeOut); end
    n_tests++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b want 0", write); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if ((write !== 1'b0) || (done !== 1'b0) || (readRequested !== 11'd0)) begin
      n_fail++; $display("FAIL idle_quiet got write=%b done=%b rd=%h want 0 0 000", write, done, readRequested);
    end
  endtask

  task automatic test_well_spaced();
    int bad;
    for (int i = 0; i < 10; i++) begin vec[i] = i * 1000; exp_v[i] = i * 1000; end
    load_vec(11'h120);
    run_frame(11'h120, -1, -1, 3);
    n_tests++; if (f_lat != 49) begin n_fail++; $display("FAIL ws_latency got %0d want 49", f_lat); end
    n_tests++; if (n_wr - f_wr0 != 10) begin n_fail++; $display("FAIL ws_nwrites got %0d want 10", n_wr - f_wr0); end
    n_tests++; if (n_rd - f_rd0 != 10) begin n_fail++; $display("FAIL ws_nreads got %0d want 10", n_rd - f_rd0); end
    n_tests++; if (n_done - f_done0 != 1) begin n_fail++; $display("FAIL ws_ndone got %0d want 1", n_done - f_done0); end
    n_tests++; if (n_clash != f_clash0) begin n_fail++; $display("FAIL ws_rw_clash got %0d want 0", n_clash - f_clash0); end
    bad = 0;
    for (int i = 0; i < 10; i++) if (rd_log[f_rd0 + i] !== 11'h120 + 11'(i)) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL ws_rdaddr got %0d wrong addresses want 0", bad); end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ((wr_addr_log[f_wr0 + i] !== 11'h120 + 11'(i)) || (wr_data_log[f_wr0 + i] !== 32'(exp_v[i]))) begin
        n_fail++; $display("FAIL ws_word%0d got %h:%h want %h:%h", i, wr_addr_log[f_wr0 + i], wr_data_log[f_wr0 + i], 11'h120 + 11'(i), 32'(exp_v[i]));
      end
    end
    n_tests++; if ((write !== 1'b0) || (writeRequested !== 11'h129) || (writeOut !== 32'd9000) || (readRequested !== 11'h129)) begin
      n_fail++; $display("FAIL ws_idle_hold got w=%b wa=%h wd=%h ra=%h want 0 129 00002328 129", write, writeRequested, writeOut, readRequested);
    end
  endtask

  task automatic test_close_pair();
    vec[0] = 100; vec[1] = 100;
    for (int i = 2; i < 10; i++) vec[i] = i * 1000;
    exp_v[0] = 95; exp_v[1] = 105;
    for (int i = 2; i < 10; i++) exp_v[i] = i * 1000;
    load_vec(11'h240);
    run_frame(11'h240, -1, -1, 3);
    n_tests++; if (f_lat != 49) begin n_fail++; $display("FAIL cp_latency got %0d want 49", f_lat); end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ((wr_addr_log[f_wr0 + i] !== 11'h240 + 11'(i)) || (wr_data_log[f_wr0 + i] !== 32'(exp_v[i]))) begin
        n_fail++; $display("FAIL cp_word%0d got %h:%h want %h:%h", i, wr_addr_log[f_wr0 + i], wr_data_log[f_wr0 + i], 11'h240 + 11'(i), 32'(exp_v[i]));
      end
    end
  endtask

  task automatic test_saturation();
    vec[0] = 32767; vec[1] = -32768;
    for (int i = 2; i < 10; i++) vec[i] = 20000 + (i - 2) * 1000;
    exp_v[0] = 1; exp_v[1] = -2;
    for (int i = 2; i < 10; i++) exp_v[i] = 20000 + (i - 2) * 1000;
    load_vec(11'h3F0);
    run_frame(11'h3F0, -1, -1, 3);
    n_tests++; if (f_lat != 49) begin n_fail++; $display("FAIL sat_latency got %0d want 49", f_lat); end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ((wr_addr_log[f_wr0 + i] !== 11'h3F0 + 11'(i)) || (wr_data_log[f_wr0 + i] !== 32'(exp_v[i]))) begin
        n_fail++; $display("FAIL sat_word%0d got %h:%h want %h:%h", i, wr_addr_log[f_wr0 + i], wr_data_log[f_wr0 + i], 11'h3F0 + 11'(i), 32'(exp_v[i]));
      end
    end
    n_tests++; if (wr_data_log[f_wr0 + 1][31:16] !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_sext got %h want ffff", wr_data_log[f_wr0 + 1][31:16]);
    end
  endtask

  task automatic test_busy_start();
    run_frame(11'h120, 10, 30, 8);
    n_tests++; if (f_lat != 49) begin n_fail++; $display("FAIL busy_latency got %0d want 49", f_lat); end
    n_tests++; if (n_rd - f_rd0 != 10) begin n_fail++; $display("FAIL busy_nreads got %0d want 10", n_rd - f_rd0); end
    n_tests++; if (n_wr - f_wr0 != 10) begin n_fail++; $display("FAIL busy_nwrites got %0d want 10", n_wr - f_wr0); end
    n_tests++; if (n_done - f_done0 != 1) begin n_fail++; $display("FAIL busy_ndone got %0d want 1", n_done - f_done0); end
  endtask

  task automatic test_start_at_done();
    run_frame(11'h240, 49, -1, 8);
    n_tests++; if (n_done - f_done0 != 1) begin n_fail++; $display("FAIL sad_ndone got %0d want 1", n_done - f_done0); end
    n_tests++; if (n_rd - f_rd0 != 10) begin n_fail++; $display("FAIL sad_nreads got %0d want 10", n_rd - f_rd0); end
    n_tests++; if (n_wr - f_wr0 != 10) begin n_fail++; $display("FAIL sad_nwrites got %0d want 10", n_wr - f_wr0); end
    n_tests++; if (wr_data_log[f_wr0 + 1] !== 32'd105) begin n_fail++; $display("FAIL sad_word1 got %h want 00000069", wr_data_log[f_wr0 + 1]); end
  endtask

  task automatic test_reset_mid_run();
    int w0, d0;
    vec[0] = 100; vec[1] = 100;
    for (int i = 2; i < 10; i++) vec[i] = i * 1000;
    exp_v[0] = 95; exp_v[1] = 105;
    for (int i = 2; i < 10; i++) exp_v[i] = i * 1000;
    load_vec(11'h500);
    @(negedge clk);
    w0 = n_wr; d0 = n_done;
    bufAddr = 11'h500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++; if (readRequested !== 11'd0) begin n_fail++; $display("FAIL rst_mid_rdaddr got %h want 000", readRequested); end
    n_tests++; if ((write !== 1'b0) || (done !== 1'b0)) begin n_fail++; $display("FAIL rst_mid_wr_done got %b %b want 0 0", write, done); end
    n_tests++; if ((writeRequested !== 11'd0) || (writeOut !== 32'd0)) begin n_fail++; $display("FAIL rst_mid_wrbus got %h %h want 0 0", writeRequested, writeOut); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    n_tests++; if (n_wr != w0) begin n_fail++; $display("FAIL rst_mid_nowrite got %0d writes want 0", n_wr - w0); end
    n_tests++; if (n_done != d0) begin n_fail++; $display("FAIL rst_mid_nodone got %0d want 0", n_done - d0); end
    run_frame(11'h500, -1, -1, 3);
    n_tests++; if (f_lat != 49) begin n_fail++; $display("FAIL rst_rerun_latency got %0d want 49", f_lat); end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ((wr_addr_log[f_wr0 + i] !== 11'h500 + 11'(i)) || (wr_data_log[f_wr0 + i] !== 32'(exp_v[i]))) begin
        n_fail++; $display("FAIL rst_rerun_word%0d got %h:%h want %h:%h", i, wr_addr_log[f_wr0 + i], wr_data_log[f_wr0 + i], 11'h500 + 11'(i), 32'(exp_v[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] base;
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < 10; i++) begin
        if (f % 3 == 0)      vec[i] = int'($urandom_range(0, 65535)) - 32768;
        else if (f % 3 == 2) vec[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        else if (i == 0)     vec[i] = int'($urandom_range(0, 2000));
        else                 vec[i] = vec[i-1] + int'($urandom_range(0, 25));
      end
      load_vec(11'((f + 40) * 16));
      for (int i = 0; i < 10; i++) mv[i] = vec[i];
      model_pass(10);
      model_pass(5);
      for (int i = 0; i < 10; i++) exp_all[f][i] = mv[i];
    end
    for (int f = 0; f < 60; f++) begin
      base = 11'((f + 40) * 16);
      run_frame(base, -1, -1, 0);
      n_tests++; if (f_lat != 49) begin n_fail++; $display("FAIL b2b_f%0d_latency got %0d want 49", f, f_lat); end
      n_tests++; if (n_wr - f_wr0 != 10) begin n_fail++; $display("FAIL b2b_f%0d_nwrites got %0d want 10", f, n_wr - f_wr0); end
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if ((wr_addr_log[f_wr0 + i] !== base + 11'(i)) || (wr_data_log[f_wr0 + i] !== 32'(exp_all[f][i]))) begin
          n_fail++; $display("FAIL b2b_f%0d_word%0d got %h:%h want %h:%h", f, i, wr_addr_log[f_wr0 + i], wr_data_log[f_wr0 + i], base + 11'(i), 32'(exp_all[f][i]));
        end
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    test_reset();
    test_well_spaced();
    test_close_pair();
    test_saturation();
    test_busy_start();
    test_start_at_done();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsp_expand_1_2.md
Name: lsp_expand_1_2

Overview:
- Upstream neighbour of the previous-frame LSP composition stage in the G.729 LSP quantizer.
- Takes the 10-coefficient reconstructed LSP vector from shared scratch memory and enforces minimum spacing with two expansion passes: gap GAP1, then gap GAP2.
- Writes the expanded vector back in place.
- The composition stage then reads this vector as its lsp_ele input.

Parameters:
- M, 10, number of LSP coefficients.
- GAP1, 10, first-pass gap (Q13).
- GAP2, 5, second-pass gap (Q13).
- ADDR_W, 11, memory address width.
- DATA_W, 32, memory data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins an operation when idle.
- bufAddr  in  ADDR_W  base address of the vector; bits [3:0] must be 0, element i is at {bufAddr[10:4], i[3:0]}.
- readRequested  out  ADDR_W  memory read address.
- readIn  in  DATA_W  memory read data; only [15:0] is used, as Q13 signed.
- writeRequested  out  ADDR_W  memory write address.
- writeOut  out  DATA_W  write data; [15:0] is the result, sign-extended to 32 bits.
- write  out  1  write enable, one word per cycle when high.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - readRequested, writeRequested, writeOut, write and done all go to 0.
  - Internal buf[0..9] and the index counters are cleared.
- Memory timing: readIn is valid on the cycle after readRequested is presented (registered RAM, one-cycle latency).
- States: IDLE -> RD_ADDR -> RD_CAP (x10) -> PASS1 -> PASS2 -> WR -> DONE -> IDLE.
- IDLE: waits for start=1; latches bufAddr[10:4] and clears index i.
- Read phase:
  - RD_ADDR drives readRequested={base,i}.
  - RD_CAP captures buf[i]=readIn[15:0], then i++.
  - After i=9 the FSM goes to PASS1.
  - 2 cycles per word, 20 cycles in total.
- PASS1 and PASS2: one step per cycle for j=1..9 (9 cycles per pass), using gap g:
  - diff = sat16(buf[j-1] - buf[j]).
  - tmp = sat16(diff + g) >>> 1 (arithmetic shift).
  - If tmp > 0: buf[j-1] = sat16(buf[j-1] - tmp) and buf[j] = sat16(buf[j] + tmp).
  - Otherwise buf is unchanged.
  - Step j uses the results of step j-1 (sequential dependency).
- Saturation: sat16 clamps to the range [-32768, 32767]. All intermediates are computed at 17 bits before clamping.
- WR phase:
  - For i=0..9, one word per cycle: write=1, writeRequested={base,i}, writeOut=sext(buf[i]).
  - write drops to 0 after i=9.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at cycle 0 means done is high at cycle 49 (20 read + 18 compute + 10 write + 1).
- start while not in IDLE: ignored; no restart, no queueing.
- start on the same cycle that done is high: ignored. A new operation may start from the first IDLE cycle after done.
- Reset mid-operation: aborts immediately and no further writes are issued. Any words already written remain; the partial result is not completed. The next start after reset runs normally.
- Outputs in idle:
  - readRequested holds its last address.
  - writeRequested and writeOut hold their last values.
  - write is 0.
- Memory access exclusivity: the block never reads and writes in the same cycle.

Test Plan:
- Well-spaced vector: buf = 0, 1000, ..., 9000 at base 0x120 -> all diffs negative, no change; 10 writes return 0, 1000, ..., 9000; done at cycle 49 after start.
- Close pair: buf = 100, 100, 2000, 3000, ..., 9000 -> PASS1 j=1 gives 95, 105; PASS2 j=1 tmp=-3, no change; result 95, 105, 2000, ..., 9000.
- Saturation: buf = 32767, -32768, 20000, 21000, ..., 27000 -> PASS1 gives 16384, -16385; PASS2 gives diff sat 32767, tmp 16383; result 1, -2, 20000, ..., 27000; writeOut[31:16]=0xFFFF for the -2 word.
- Busy start: pulse start again at cycle 10 and at cycle 30 -> ignored; exactly 10 reads, 10 writes and one done pulse.
- Reset mid-run: drop reset at cycle 25 (PASS1) -> all outputs go to 0 asynchronously; no writes and no done. Reload the close-pair vector and start -> correct result 95, 105, ...
- Back-to-back: 60 frames, each starting on the first IDLE cycle after done -> each frame's written vector matches the ITU C reference Lsp_expand_1_2(GAP1) followed by Lsp_expand_1_2(GAP2).
